gf2mz_add_pipe: RTL and testbench

GF2MZ_ADD_PIPE -- requirements
Module: gf2mz_add_pipe

---
 rtl/gf2mz_pkg.sv | 25 ++
 rtl/gf2mz_rd_pipe.sv | 54 +++++
 rtl/gf2mz_add_pipe.sv | 152 +++++++++++++++
 tb/tb_gf2mz_add_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gf2mz_pkg.sv
// Shared definitions for the GF(2^m)[z] polynomial add/copy pipeline:
// operation encodings, controller states and a constant log2 helper.
package gf2mz_pkg;

  localparam logic [1:0] MODE_ADD    = 2'd0;
  localparam logic [1:0] MODE_PASS_A = 2'd1;
  localparam logic [1:0] MODE_PASS_B = 2'd2;
  localparam logic [1:0] MODE_CLR    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // ceil(log2(value)); 0 for value <= 1
  function automatic int gf2mz_clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/gf2mz_rd_pipe.sv
// Tracks in-flight operand reads: valid/address/last delayed by the memory
// read latency so write-back lines up with returning data.
module gf2mz_rd_pipe #(
  parameter int DELAY_rd = 1,
  parameter int AW       = 3
) (
  input  logic          clk,
  input  logic          i_clr,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  input  logic          i_last,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  genvar gi;
  for (gi = 0; gi < DELAY_rd; gi++) begin : g_stage
    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic          r_last;
    logic          w_valid_in;
    logic [AW-1:0] w_addr_in;
    logic          w_last_in;

    if (gi == 0) begin : g_head
      assign w_valid_in = i_valid;
      assign w_addr_in  = i_addr;
      assign w_last_in  = i_last;
    end else begin : g_tail
      assign w_valid_in = g_stage[gi-1].r_valid;
      assign w_addr_in  = g_stage[gi-1].r_addr;
      assign w_last_in  = g_stage[gi-1].r_last;
    end

    // Idle slots carry zero address/last so the tail is clean when invalid
    always_ff @(posedge clk) begin
      if (i_clr) begin
        r_valid <= 1'b0;
        r_addr  <= '0;
        r_last  <= 1'b0;
      end else begin
        r_valid <= w_valid_in;
        r_addr  <= w_valid_in ? w_addr_in : '0;
        r_last  <= w_valid_in & w_last_in;
      end
    end
  end

  assign o_valid = g_stage[DELAY_rd-1].r_valid;
  assign o_addr  = g_stage[DELAY_rd-1].r_addr;
  assign o_last  = g_stage[DELAY_rd-1].r_last;

endmodule

// File: rtl/gf2mz_add_pipe.sv
// Streams L words of two GF(2^m)[z] operands through add/copy/clear at one
// word per cycle, writing results to C with unused top elements zeroed.
module gf2mz_add_pipe
  import gf2mz_pkg::*;
#(
  parameter int n        = 47,
  parameter int m        = 101,
  parameter int d        = 6,
  parameter int WIDTH    = m * d,
  parameter int DEPTH    = (n + d - 1) / d,
  parameter int DELAY_rd = 1,
  localparam int AW      = (gf2mz_clog2(DEPTH) < 1) ? 1 : gf2mz_clog2(DEPTH),
  localparam int LW      = gf2mz_clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LW-1:0]    len,
  output logic [AW-1:0]    A_addr,
  output logic [AW-1:0]    B_addr,
  input  logic [WIDTH-1:0] A_di,
  input  logic [WIDTH-1:0] B_di,
  output logic [AW-1:0]    C_addr,
  output logic [WIDTH-1:0] C_do,
  output logic             C_we,
  output logic             busy,
  output logic             done
);

  localparam int            REM       = n % d;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    r_last_idx;
  logic [1:0]       r_mode;
  logic             r_we;
  logic [AW-1:0]    r_caddr;
  logic [WIDTH-1:0] r_cdo;
  logic             r_done;

  logic             w_issue;
  logic             w_issue_last;
  logic             w_rd_valid;
  logic [AW-1:0]    w_rd_addr;
  logic             w_rd_last;
  logic             w_last_word;
  logic [LW-1:0]    w_len_eff;
  logic [WIDTH-1:0] w_word;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = (len == '0) ? ST_FIN : ST_ISSUE;
      ST_ISSUE: if (w_issue_last) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_rd_valid && w_rd_last) w_state_next = ST_FIN;
      ST_FIN:   w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (r_state != ST_IDLE);
    w_issue      = (r_state == ST_ISSUE);
    w_issue_last = w_issue && (r_cnt == r_last_idx);
  end

  assign w_len_eff = (len > DEPTH_L) ? DEPTH_L : len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_last_idx <= '0;
      r_mode     <= MODE_ADD;
      r_we       <= 1'b0;
      r_caddr    <= '0;
      r_cdo      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done  <= (r_state == ST_FIN);
      r_we    <= w_rd_valid;
      r_caddr <= w_rd_valid ? w_rd_addr : '0;
      r_cdo   <= w_rd_valid ? w_word : '0;
      if (r_state == ST_IDLE && start) begin
        r_mode     <= mode;
        r_last_idx <= AW'(w_len_eff - LW'(1));
        r_cnt      <= '0;
      end else if (w_issue) begin
        // Counter parks at zero after the final address instead of wrapping
        r_cnt <= w_issue_last ? '0 : r_cnt + AW'(1);
      end
    end
  end

  assign A_addr = r_cnt;
  assign B_addr = r_cnt;
  assign C_we   = r_we;
  assign C_addr = r_caddr;
  assign C_do   = r_cdo;
  assign done   = r_done;

  gf2mz_rd_pipe #(
    .DELAY_rd(DELAY_rd),
    .AW      (AW)
  ) u_rd_pipe (
    .clk    (clk),
    .i_clr  (rst),
    .i_valid(w_issue),
    .i_addr (r_cnt),
    .i_last (w_issue_last),
    .o_valid(w_rd_valid),
    .o_addr (w_rd_addr),
    .o_last (w_rd_last)
  );

  assign w_last_word = (w_rd_addr == LAST_ADDR);

  genvar gi;
  for (gi = 0; gi < d; gi++) begin : g_elem
    logic [m-1:0] w_a;
    logic [m-1:0] w_b;
    logic [m-1:0] w_f;

    assign w_a = A_di[gi*m +: m];
    assign w_b = B_di[gi*m +: m];

    // Addition in GF(2^m) is coefficient-wise XOR, no carries between elements
    always_comb begin
      case (r_mode)
        MODE_ADD:    w_f = w_a ^ w_b;
        MODE_PASS_A: w_f = w_a;
        MODE_PASS_B: w_f = w_b;
        default:     w_f = '0;
      endcase
    end

    if (REM != 0 && gi >= REM) begin : g_mask
      assign w_word[gi*m +: m] = w_last_word ? '0 : w_f;
    end else begin : g_keep
      assign w_word[gi*m +: m] = w_f;
    end
  end

endmodule

// File: tb/tb_gf2mz_add_pipe.sv
// Drives three parameterisations of gf2mz_add_pipe in lockstep and checks
// every output each cycle against a latency/contents model of each job.
module tb_gf2mz_add_pipe;

  localparam int M     = 101;
  localparam int DE    = 6;
  localparam int W     = M * DE;
  localparam int DEPTH = 8;
  localparam int NI    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode  = 2'd0;
  logic [3:0] len   = 4'd0;

  logic [W-1:0] memA [DEPTH];
  logic [W-1:0] memB [DEPTH];

  logic [2:0]   a_addr [NI];
  logic [2:0]   b_addr [NI];
  logic [2:0]   c_addr [NI];
  logic [W-1:0] a_di   [NI];
  logic [W-1:0] b_di   [NI];
  logic [W-1:0] c_do   [NI];
  logic         c_we   [NI];
  logic         busy   [NI];
  logic         done   [NI];
  logic [2:0]   ha     [NI][4];
  logic [2:0]   hb     [NI][4];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // job model per instance
  bit jv [NI];
  int js [NI];
  int jl [NI];
  int jm [NI];

  gf2mz_add_pipe #(.DELAY_rd(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
    .A_addr(a_addr[0]), .B_addr(b_addr[0]), .A_di(a_di[0]), .B_di(b_di[0]),
    .C_addr(c_addr[0]), .C_do(c_do[0]), .C_we(c_we[0]), .busy(busy[0]), .done(done[0]));

  gf2mz_add_pipe #(.DELAY_rd(3)) u1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
    .A_addr(a_addr[1]), .B_addr(b_addr[1]), .A_di(a_di[1]), .B_di(b_di[1]),
    .C_addr(c_addr[1]), .C_do(c_do[1]), .C_we(c_we[1]), .busy(busy[1]), .done(done[1]));

  gf2mz_add_pipe #(.n(48), .DELAY_rd(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
    .A_addr(a_addr[2]), .B_addr(b_addr[2]), .A_di(a_di[2]), .B_di(b_di[2]),
    .C_addr(c_addr[2]), .C_do(c_do[2]), .C_we(c_we[2]), .busy(busy[2]), .done(done[2]));

  // Operand memories with DELAY_rd cycles of read latency per instance
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      ha[i][0] <= a_addr[i];
      hb[i][0] <= b_addr[i];
      for (int j = 1; j < 4; j++) begin
        ha[i][j] <= ha[i][j-1];
        hb[i][j] <= hb[i][j-1];
      end
    end
  end

  assign a_di[0] = memA[ha[0][0]];
  assign b_di[0] = memB[hb[0][0]];
  assign a_di[1] = memA[ha[1][2]];
  assign b_di[1] = memB[hb[1][2]];
  assign a_di[2] = memA[ha[2][1]];
  assign b_di[2] = memB[hb[2][1]];

  function automatic int dly(int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [639:0] t;
    for (int j = 0; j < 20; j++) t[j*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  task automatic fill_mem();
    for (int k = 0; k < DEPTH; k++) begin
      memA[k] = rnd_word();
      memB[k] = rnd_word();
    end
  endtask

  function automatic logic [W-1:0] exp_word(int md, int k, bit partial);
    logic [W-1:0] r;
    case (md)
      0:       r = memA[k] ^ memB[k];
      1:       r = memA[k];
      2:       r = memB[k];
      default: r = '0;
    endcase
    if (partial && k == DEPTH - 1)
      for (int b = M * (47 % DE); b < W; b++) r[b] = 1'b0;
    return r;
  endfunction

  function automatic int done_cyc(int i);
    return (jl[i] == 0) ? js[i] + 2 : js[i] + 2 + jl[i] + dly(i);
  endfunction

  task automatic chk(string tag, int inst, logic [W-1:0] obs, logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s u%0d cyc=%0d observed=%h expected=%h", tag, inst, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      logic         ewe, edn, ebs;
      logic [2:0]   ea, er;
      logic [W-1:0] ed;
      int           k, dc;
      ewe = 1'b0; edn = 1'b0; ebs = 1'b0; ea = '0; er = '0; ed = '0;
      if (jv[i]) begin
        dc = done_cyc(i);
        k  = cyc - js[i] - 2 - dly(i);
        if (k >= 0 && k < jl[i]) begin
          ewe = 1'b1;
          ea  = 3'(k);
          ed  = exp_word(jm[i], k, i != 2);
        end
        edn = (cyc == dc);
        ebs = (cyc > js[i]) && (cyc < dc);
        if (cyc >= js[i] + 1 && cyc <= js[i] + jl[i]) er = 3'(cyc - js[i] - 1);
      end
      chk("C_we",   i, W'(c_we[i]),   W'(ewe));
      chk("C_addr", i, W'(c_addr[i]), W'(ea));
      chk("C_do",   i, c_do[i],       ed);
      chk("done",   i, W'(done[i]),   W'(edn));
      chk("busy",   i, W'(busy[i]),   W'(ebs));
      chk("A_addr", i, W'(a_addr[i]), W'(er));
      chk("B_addr", i, W'(b_addr[i]), W'(er));
    end
  endtask

  // One clock: drive inputs for cycle cyc, update model at the edge, check cyc+1
  task automatic tick(bit st, logic [1:0] md, logic [3:0] ln, bit rs);
    start = st;
    mode  = md;
    len   = ln;
    rst   = rs;
    if (st && !rs) $display("cyc=%0d start mode=%0d len=%0d", cyc, md, ln);
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (rs) begin
        jv[i] = 1'b0;
      end else if (st && (!jv[i] || cyc >= done_cyc(i))) begin
        jv[i] = 1'b1;
        js[i] = cyc;
        jm[i] = int'(md);
        jl[i] = (ln > 4'd8) ? 8 : int'(ln);
      end
    end
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_n(int k);
    for (int c = 0; c < k; c++) tick(1'b0, 2'($urandom), 4'($urandom), 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) jv[i] = 1'b0;
    fill_mem();
    tick(1'b0, 2'd0, 4'd0, 1'b1);
    tick(1'b0, 2'd0, 4'd0, 1'b1);
    idle_n(2);

    // each mode over a full operand, random data
    tick(1'b1, 2'd0, 4'd8, 1'b0); idle_n(20);
    fill_mem();
    tick(1'b1, 2'd1, 4'd8, 1'b0); idle_n(20);
    fill_mem();
    tick(1'b1, 2'd2, 4'd8, 1'b0); idle_n(20);

    // empty job
    tick(1'b1, 2'd3, 4'd0, 1'b0); idle_n(6);

    // oversize length plus a start pulse while busy
    fill_mem();
    tick(1'b1, 2'd0, 4'd12, 1'b0); idle_n(3);
    tick(1'b1, 2'd1, 4'd5, 1'b0);  idle_n(20);

    // abort with reset at job cycle 5, restart at cycle 7
    fill_mem();
    tick(1'b1, 2'd0, 4'd8, 1'b0); idle_n(4);
    tick(1'b0, 2'd0, 4'd0, 1'b1); idle_n(1);
    tick(1'b1, 2'd1, 4'd8, 1'b0); idle_n(20);

    // start in the first cycle after reset releases
    tick(1'b0, 2'd0, 4'd0, 1'b1);
    tick(1'b1, 2'd2, 4'd7, 1'b0); idle_n(20);

    // random jobs with stray starts and input churn
    for (int j = 0; j < 8; j++) begin
      fill_mem();
      tick(1'b1, 2'($urandom), 4'($urandom), 1'b0);
      for (int c = 0; c < 16; c++)
        tick(($urandom % 5) == 0, 2'($urandom), 4'($urandom), 1'b0);
      idle_n(16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
